// File: rtl/tinyalu_pkg.sv
// Shared types and widths for the tinyalu memory-side blocks.
// Holds the arbiter FSM encoding, the latched memory-op record and the
// default memory port widths used by mem_port_arbiter.
package tinyalu_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 16;

  // Width of the BUSY wait counter used by the optional timeout.
  localparam int ARB_WAIT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_op_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first valid requester after last_grant, wrapping mod NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the grant.
// Ports: req_valid (per-requester pending), last_grant (index of previous winner),
//        grant (one-hot winner, all-zero if none), grant_idx (binary winner index).
module rr_picker #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_valid,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NREQ);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan starts one past the previous winner; the previous winner is the
  // last candidate, so a lone requester still wins every arbitration.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of the single memory port between NREQ requesters, one op in flight.
// Latency: req_ready 1 cycle after accept, rsp_valid 1 cycle after mem_resp; >= 3 cycles + memory per op.
// Backpressure: requesters hold valid until req_ready; memory stalls BUSY until mem_resp (or timeout).
// Ports: req_valid/req_write/req_addr/req_wdata in, req_ready out (one-hot accept pulse);
//        rsp_valid (one-hot), rsp_rdata, rsp_err out; cs/read_req/write_req/addrout/datatomem
//        to memory, datafrommem/mem_resp from memory. clk, reset (sync, active-high).
// Optional: define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES with rsp_err=1.
module mem_port_arbiter
  import tinyalu_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   cs,
  output logic                   read_req,
  output logic                   write_req,
  output logic [ADDR_W-1:0]      addrout,
  output logic [DATA_W-1:0]      datatomem,
  input  logic [DATA_W-1:0]      datafrommem,
  input  logic                   mem_resp
);

  localparam int IDX_W = $clog2(NREQ);

  arb_state_t       state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] gnt_idx;
  logic             op_write;
  logic [NREQ-1:0]  pick_grant;
  logic [IDX_W-1:0] pick_idx;

`ifdef MEM_TIMEOUT_EN
  logic [ARB_WAIT_W-1:0] wait_cnt;
  logic                  timed_out;
  // wait_cnt holds (BUSY cycle number - 1), so this fires in BUSY cycle TIMEOUT_CYCLES.
  assign timed_out = (wait_cnt == ARB_WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  // Timeout hardware is not built; the parameter is kept for a uniform interface.
  logic [ARB_WAIT_W-1:0] unused_timeout;
  assign unused_timeout = ARB_WAIT_W'(TIMEOUT_CYCLES);
  assign rsp_err        = 1'b0;
`endif

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .grant_idx  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= IDX_W'(NREQ - 1);
      gnt_idx    <= '0;
      op_write   <= 1'b0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      cs         <= 1'b0;
      read_req   <= 1'b0;
      write_req  <= 1'b0;
      addrout    <= '0;
      datatomem  <= '0;
`ifdef MEM_TIMEOUT_EN
      rsp_err    <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      req_ready <= '0;
      rsp_valid <= '0;
`ifdef MEM_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
      case (state)
        ARB_IDLE: begin
          if (|req_valid) begin
            req_ready  <= pick_grant;
            gnt_idx    <= pick_idx;
            last_grant <= pick_idx;
            op_write   <= req_write[pick_idx];
            cs         <= 1'b1;
            read_req   <= !req_write[pick_idx];
            write_req  <= req_write[pick_idx];
            addrout    <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            datatomem  <= req_wdata[pick_idx*DATA_W +: DATA_W];
`ifdef MEM_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
            state      <= ARB_BUSY;
          end
        end

        ARB_BUSY: begin
          // mem_resp is checked first so it wins over a same-cycle timeout.
          if (mem_resp) begin
            rsp_valid <= NREQ'(1'b1) << gnt_idx;
            rsp_rdata <= op_write ? '0 : datafrommem;
            cs        <= 1'b0;
            read_req  <= 1'b0;
            write_req <= 1'b0;
            state     <= ARB_RESP;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timed_out) begin
            rsp_valid <= NREQ'(1'b1) << gnt_idx;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            cs        <= 1'b0;
            read_req  <= 1'b0;
            write_req <= 1'b0;
            state     <= ARB_RESP;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
          end
`endif
        end

        ARB_RESP: begin
          rsp_rdata <= '0;
          state     <= ARB_IDLE;
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single ops plus hand-written
// sequences for contention, reset mid-op, withdrawn request and long waits.
// Inputs change 1 time unit after posedge; outputs are sampled at that point.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        cs;
  logic        read_req;
  logic        write_req;
  logic [13:0] addrout;
  logic [15:0] datatomem;
  logic [15:0] datafrommem;
  logic        mem_resp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic        wr;
    logic [13:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] mdata;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rsp;
    logic [15:0] exp_rdata;
  } vec_t;

  mem_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .cs          (cs),
    .read_req    (read_req),
    .write_req   (write_req),
    .addrout     (addrout),
    .datatomem   (datatomem),
    .datafrommem (datafrommem),
    .mem_resp    (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One op on a single port; memory answers in BUSY cycle v.lat.
  task automatic run_op(input vec_t v, input string name);
    int n;
    bit done;
    req_valid               = '0;
    req_valid[v.port]       = 1'b1;
    req_write[v.port]       = v.wr;
    req_addr[v.port*14 +: 14] = v.addr;
    req_wdata[v.port*16 +: 16] = v.wdata;
    @(posedge clk); #1;
    chk({name, ".ready"}, req_ready, v.exp_ready);
    req_valid = '0;
    n = 0;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (cs) begin
        n++;
        chk({name, ".addrout"}, addrout, v.addr);
        chk({name, ".read_req"}, read_req, !v.wr);
        chk({name, ".write_req"}, write_req, v.wr);
        chk({name, ".datatomem"}, datatomem, v.wdata);
        mem_resp    = (n == v.lat);
        datafrommem = v.mdata;
        @(posedge clk); #1;
        mem_resp    = 1'b0;
        datafrommem = '0;
      end else begin
        done = 1'b1;
      end
    end
    chk({name, ".bounded"}, done, 1);
    chk({name, ".busy_cycles"}, n, v.lat);
    chk({name, ".rsp_valid"}, rsp_valid, v.exp_rsp);
    chk({name, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({name, ".rsp_err"}, rsp_err, 0);
    chk({name, ".no_ready_in_resp"}, req_ready, 0);
    @(posedge clk); #1;
    chk({name, ".rsp_pulse_end"}, rsp_valid, 0);
  endtask

  // Port0 load with mem_resp in BUSY cycle resp_at (0 = never).
  task automatic long_op(input int resp_at, input int exp_cycles, input logic exp_err,
                         input logic [15:0] exp_rdata, input string name);
    int n;
    bit done;
    req_valid     = 2'b01;
    req_write[0]  = 1'b0;
    req_addr[13:0] = 14'h0055;
    @(posedge clk); #1;
    chk({name, ".ready"}, req_ready, 2'b01);
    req_valid = '0;
    n = 0;
    done = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (cs) begin
        n++;
        mem_resp    = (n == resp_at);
        datafrommem = 16'h7777;
        @(posedge clk); #1;
        mem_resp    = 1'b0;
        datafrommem = '0;
      end else begin
        done = 1'b1;
      end
    end
    chk({name, ".bounded"}, done, 1);
    chk({name, ".busy_cycles"}, n, exp_cycles);
    chk({name, ".rsp_valid"}, rsp_valid, 2'b01);
    chk({name, ".rsp_err"}, rsp_err, exp_err);
    chk({name, ".rsp_rdata"}, rsp_rdata, exp_rdata);
    @(posedge clk); #1;
    chk({name, ".rsp_pulse_end"}, rsp_valid, 0);
  endtask

  vec_t vecs[4];
  vec_t v_after_rst;
  int   order[4];
  int   grants;
  int   rsps;
  int   cnt;
  bit   overlap;

  initial begin
    //             port wr  addr      wdata     lat mdata     ready  rsp    rdata
    vecs[0] = '{0, 1'b0, 14'h0123, 16'h0000, 5, 16'hBEEF, 2'b01, 2'b01, 16'hBEEF};
    vecs[1] = '{1, 1'b1, 14'h3FFF, 16'hA5A5, 1, 16'h1234, 2'b10, 2'b10, 16'h0000};
    vecs[2] = '{0, 1'b1, 14'h0000, 16'hFFFF, 2, 16'h4321, 2'b01, 2'b01, 16'h0000};
    vecs[3] = '{1, 1'b0, 14'h2AAA, 16'h1111, 3, 16'h5A5A, 2'b10, 2'b10, 16'h5A5A};
    v_after_rst = '{1, 1'b0, 14'h1357, 16'h0000, 2, 16'h0BAD, 2'b10, 2'b10, 16'h0BAD};

    reset       = 1'b1;
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    datafrommem = '0;
    mem_resp    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.req_ready", req_ready, 0);
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.rsp_rdata", rsp_rdata, 0);
    chk("reset.rsp_err", rsp_err, 0);
    chk("reset.cs", cs, 0);
    chk("reset.strobes", {read_req, write_req}, 0);
    chk("reset.addrout", addrout, 0);
    chk("reset.datatomem", datatomem, 0);
    reset = 1'b0;

    // mem_resp in IDLE is ignored
    mem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_resp.cs", cs, 0);
      chk("idle_resp.rsp_valid", rsp_valid, 0);
    end
    mem_resp = 1'b0;

    // Single ops from the table
    for (int i = 0; i < 4; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Contention: both ports continuously valid for 4 ops (last grant was port1)
    req_write = '0;
    req_addr  = {14'h0020, 14'h0010};
    req_valid = 2'b11;
    grants = 0;
    rsps = 0;
    cnt = 0;
    overlap = 1'b0;
    for (int c = 0; c < 60 && rsps < 4; c++) begin
      @(posedge clk); #1;
      if ((|req_ready) && (|rsp_valid)) overlap = 1'b1;
      if (|req_ready) begin
        chk("cont.grant_onehot", $countones(req_ready), 1);
        chk("cont.grant_order", req_ready[1] ? 1 : 0, grants % 2);
        if (grants < 4) order[grants] = req_ready[1] ? 1 : 0;
        grants++;
        if (grants == 4) req_valid = '0;
      end
      if (|rsp_valid) begin
        if (rsps < grants) begin
          chk("cont.rsp_port", rsp_valid, 1 << order[rsps]);
          chk("cont.rsp_rdata", rsp_rdata, 16'hC000 + 16'(rsps));
        end else begin
          chk("cont.rsp_without_grant", rsps, grants);
        end
        rsps++;
      end
      if (cs) begin
        cnt++;
        if (cnt == 1 && grants > 0)
          chk("cont.addrout", addrout, (order[grants-1] == 1) ? 14'h0020 : 14'h0010);
      end else begin
        cnt = 0;
      end
      mem_resp    = cs && (cnt == 2);
      datafrommem = 16'hC000 + 16'(grants - 1);
    end
    mem_resp = 1'b0;
    chk("cont.grants", grants, 4);
    chk("cont.rsps", rsps, 4);
    chk("cont.no_overlap", overlap, 0);

    // Withdrawn request: port1 valid for one cycle while port0 is BUSY
    @(posedge clk); #1;
    req_addr[13:0] = 14'h0077;
    req_valid = 2'b01;
    @(posedge clk); #1;
    chk("wd.ready0", req_ready, 2'b01);
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid   = 2'b00;
    mem_resp    = 1'b1;
    datafrommem = 16'h600D;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    chk("wd.rsp_valid", rsp_valid, 2'b01);
    chk("wd.rsp_rdata", rsp_rdata, 16'h600D);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("wd.no_grant", req_ready, 0);
      chk("wd.idle_cs", cs, 0);
    end

    // Reset on the 3rd BUSY cycle of a port0 load
    req_write[0]   = 1'b0;
    req_addr[13:0] = 14'h0321;
    req_valid      = 2'b01;
    @(posedge clk); #1;
    chk("rst.ready", req_ready, 2'b01);
    req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst.busy3_cs", cs, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst.cs_dropped", cs, 0);
    chk("rst.read_dropped", read_req, 0);
    chk("rst.no_rsp", rsp_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst.no_late_rsp", rsp_valid, 0);
      chk("rst.idle", cs, 0);
    end
    run_op(v_after_rst, "rst.port1");

    // Long memory wait
`ifdef MEM_TIMEOUT_EN
    long_op(0, 16, 1'b1, 16'h0000, "tmo.abort");
    long_op(16, 16, 1'b0, 16'h7777, "tmo.resp_wins");
`else
    long_op(40, 40, 1'b0, 16'h7777, "wait.long");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
